conv_out_buffer: RTL and testbench

Output buffer and stream framer directly downstream of the convolution quantisation stage. The quantisation pipeline issues valid beats up to PIPE_LAT cycles after it samples its ready input and cannot stall in flight. This block therefore absorbs those beats in a FIFO, holds upstream off early enough that nothing is lost, and re-emits the quantised feature map as an AXI-stream. M_Last marks the final beat of the frame, and a Done pulse ends the layer.

---
 rtl/conv_out_buffer.sv | 139 +++++++++++++
 tb/tb_conv_out_buffer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_out_buffer.sv
// Output buffer and AXI-stream framer behind the convolution quantisation stage.
// Absorbs non-stallable upstream beats in a FIFO and frames them with M_Last/Done.
module conv_out_buffer #(
  parameter int unsigned PICTURE_NUM           = 1,
  parameter int unsigned CHANNEL_OUT_NUM       = 8,
  parameter int unsigned WIDTH_DATA            = 8,
  parameter int unsigned DATA_W                = PICTURE_NUM * CHANNEL_OUT_NUM * WIDTH_DATA,
  parameter int unsigned WIDTH_FEATURE_SIZE    = 12,
  parameter int unsigned WIDTH_CHANNEL_NUM_REG = 10,
  parameter int unsigned FIFO_DEPTH            = 64,
  parameter int unsigned PIPE_LAT              = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             Start,
  input  logic [WIDTH_FEATURE_SIZE-1:0]    Row_Num_Out_REG,
  input  logic [WIDTH_CHANNEL_NUM_REG-1:0] Channel_Out_Num_REG,
  input  logic [DATA_W-1:0]                S_Data,
  input  logic                             S_Valid,
  output logic                             S_Ready,
  output logic [DATA_W-1:0]                M_Data,
  output logic                             M_Valid,
  input  logic                             M_Ready,
  output logic                             M_Last,
  output logic                             Done,
  output logic                             Overflow
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned WF = WIDTH_FEATURE_SIZE;
  localparam int unsigned WC = WIDTH_CHANNEL_NUM_REG;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     fifo_cnt, occ;
  logic              out_valid;
  logic [WF-1:0]     n_reg, col, row;
  logic [WC-1:0]     c_reg, chan;
  logic              running, hs, at_last, rd_en, wr_en;

  always_comb begin
    running = (state == RUN);
    hs      = out_valid && M_Ready;
    at_last = (chan == c_reg - WC'(1)) && (col == n_reg - WF'(1)) && (row == n_reg - WF'(1));
    // The output register is not refilled on the final handshake, so later
    // beats stay queued for the next frame.
    rd_en   = running && (fifo_cnt != '0) && (!out_valid || M_Ready) && !(hs && at_last);
    wr_en   = running && S_Valid && ((fifo_cnt != CW'(FIFO_DEPTH)) || rd_en);
    occ     = fifo_cnt + CW'(out_valid);
  end

  assign S_Ready = (32'(occ) + PIPE_LAT) < FIFO_DEPTH;
  assign M_Valid = out_valid;
  assign M_Last  = out_valid && at_last;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= S_Data;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fifo_cnt  <= '0;
      out_valid <= 1'b0;
      M_Data    <= '0;
      Done      <= 1'b0;
      Overflow  <= 1'b0;
      n_reg     <= '0;
      c_reg     <= '0;
      chan      <= '0;
      col       <= '0;
      row       <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) begin
        rd_ptr    <= rd_ptr + AW'(1);
        M_Data    <= mem[rd_ptr];
        out_valid <= 1'b1;
      end else if (hs) begin
        out_valid <= 1'b0;
      end
      case ({wr_en, rd_en})
        2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase

      case (state)
        IDLE: begin
          Done <= 1'b0;
          if (Start) begin
            n_reg    <= Row_Num_Out_REG;
            c_reg    <= Channel_Out_Num_REG;
            chan     <= '0;
            col      <= '0;
            row      <= '0;
            Overflow <= 1'b0;
            state    <= ((Row_Num_Out_REG == '0) || (Channel_Out_Num_REG == '0)) ? DONE : RUN;
          end
        end
        RUN: begin
          if (hs) begin
            if (chan == c_reg - WC'(1)) begin
              chan <= '0;
              if (col == n_reg - WF'(1)) begin
                col <= '0;
                row <= row + WF'(1);
              end else begin
                col <= col + WF'(1);
              end
            end else begin
              chan <= chan + WC'(1);
            end
            if (at_last) begin
              state <= DONE;
              Done  <= 1'b1;
            end
          end
        end
        DONE: begin
          // Entered via the last handshake Done is already high; the zero-size
          // path raises it here instead, one cycle later.
          Done  <= !Done;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (S_Valid && !wr_en) Overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_conv_out_buffer.sv
// Scoreboard bench for conv_out_buffer: stimulus pushes expected beats, a
// negedge monitor pops and compares on every output handshake.
module tb_conv_out_buffer;

  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          Start = 1'b0;
  logic [11:0]   Row_Num_Out_REG = '0;
  logic [9:0]    Channel_Out_Num_REG = '0;
  logic [DW-1:0] S_Data = '0;
  logic          S_Valid = 1'b0;
  logic          S_Ready;
  logic [DW-1:0] M_Data;
  logic          M_Valid;
  logic          M_Ready = 1'b0;
  logic          M_Last;
  logic          Done;
  logic          Overflow;

  conv_out_buffer #(
    .CHANNEL_OUT_NUM(8),
    .WIDTH_DATA(8),
    .FIFO_DEPTH(64),
    .PIPE_LAT(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .Start(Start),
    .Row_Num_Out_REG(Row_Num_Out_REG),
    .Channel_Out_Num_REG(Channel_Out_Num_REG),
    .S_Data(S_Data),
    .S_Valid(S_Valid),
    .S_Ready(S_Ready),
    .M_Data(M_Data),
    .M_Valid(M_Valid),
    .M_Ready(M_Ready),
    .M_Last(M_Last),
    .Done(Done),
    .Overflow(Overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          l;
  } exp_t;

  exp_t          q[$];
  exp_t          e;
  int            total = 0;
  int            bad = 0;
  int            done_cnt = 0;
  logic          stalled = 1'b0;
  logic          done_due = 1'b0;
  logic [DW-1:0] held_d;
  logic          held_l;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: output ordering, stall stability and Done one cycle after the last beat.
  always @(negedge clk) begin
    if (!rst) begin
      stalled  = 1'b0;
      done_due = 1'b0;
    end else begin
      if (done_due) begin
        check("done_after_last", Done, 1);
        done_due = 1'b0;
      end
      if (Done) done_cnt++;
      if (stalled) begin
        check("hold_valid", M_Valid, 1);
        check("hold_data", M_Data, held_d);
        check("hold_last", M_Last, held_l);
      end
      if (M_Valid && M_Ready) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_beat: actual=%0h expected=none at %0t", M_Data, $time);
        end else begin
          e = q.pop_front();
          check("m_data", M_Data, e.d);
          check("m_last", M_Last, e.l);
          if (e.l) done_due = 1'b1;
        end
      end
      stalled = M_Valid && !M_Ready;
      held_d  = M_Data;
      held_l  = M_Last;
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input int n, input int c);
    Row_Num_Out_REG     = 12'(n);
    Channel_Out_Num_REG = 10'(c);
    Start = 1'b1;
    step();
    Start = 1'b0;
  endtask

  task automatic send(input logic [DW-1:0] d, input logic l, input bit kept);
    S_Valid = 1'b1;
    S_Data  = d;
    if (kept) q.push_back('{d: d, l: l});
    step();
    S_Valid = 1'b0;
  endtask

  task automatic wait_q(input int target, input bit toggle);
    for (int i = 0; i < 400 && q.size() > target; i++) begin
      if (toggle) M_Ready = ~M_Ready;
      step();
    end
    check("drain_level", q.size(), target);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_s_ready"}, S_Ready, 1);
    check({tag, "_m_valid"}, M_Valid, 0);
    check({tag, "_m_last"}, M_Last, 0);
    check({tag, "_m_data"}, M_Data, 0);
    check({tag, "_done"}, Done, 0);
    check({tag, "_overflow"}, Overflow, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1);
  end

  initial begin
    int cnt;
    int zn[2];
    int zc[2];
    zn = '{0, 3};
    zc = '{5, 0};

    step();
    step();
    check_reset("reset");
    rst = 1'b1;
    M_Ready = 1'b1;
    step();

    // 2x2 map, 3 channel groups: 12 beats streamed back-to-back
    done_cnt = 0;
    start_frame(2, 3);
    fork
      for (int i = 0; i < 12; i++) send(DW'(i), i == 11, 1'b1);
      begin
        @(negedge clk);
        @(negedge clk);
        check("latency_t1", M_Valid, 0);
        @(negedge clk);
        check("latency_t2", M_Valid, 1);
      end
    join
    wait_q(0, 1'b0);
    step();
    step();
    check("t1_done_count", done_cnt, 1);

    // Backpressure: S_Ready falls at occ=48, 16 in-flight beats must still fit
    M_Ready = 1'b0;
    done_cnt = 0;
    start_frame(8, 1);
    cnt = 0;
    while (S_Ready && cnt < 80) begin
      send(DW'(256 + cnt), cnt == 63, 1'b1);
      cnt++;
    end
    check("s_ready_fall_count", cnt, 48);
    for (int i = 0; i < 16; i++) begin
      send(DW'(256 + cnt), cnt == 63, 1'b1);
      cnt++;
    end
    check("t2_overflow", Overflow, 0);
    check("t2_s_ready_low", S_Ready, 0);
    M_Ready = 1'b1;
    wait_q(0, 1'b0);
    step();
    step();
    check("t2_done_count", done_cnt, 1);
    check("t2_s_ready_back", S_Ready, 1);

    // Completely full (64 + output register), one extra beat is dropped;
    // the 65th kept beat carries into a 1x1 follow-up frame
    M_Ready = 1'b0;
    done_cnt = 0;
    start_frame(8, 1);
    for (int i = 0; i < 65; i++) send(DW'(512 + i), (i == 63) || (i == 64), 1'b1);
    send(64'hDEAD, 1'b0, 1'b0);
    check("t3_overflow_set", Overflow, 1);
    check("t3_s_ready_low", S_Ready, 0);
    M_Ready = 1'b1;
    wait_q(1, 1'b0);
    step();
    step();
    check("t3_done_count", done_cnt, 1);
    check("t3_overflow_sticky", Overflow, 1);
    check("t3_idle_no_valid", M_Valid, 0);
    start_frame(1, 1);
    check("t3_start_clears_ovf", Overflow, 0);
    wait_q(0, 1'b0);
    step();
    step();
    check("t3_done_count2", done_cnt, 2);

    // M_Ready toggling mid-frame
    done_cnt = 0;
    start_frame(2, 3);
    for (int i = 0; i < 12; i++) begin
      M_Ready = (i % 2 == 0);
      send(DW'(768 + i), i == 11, 1'b1);
    end
    wait_q(0, 1'b1);
    M_Ready = 1'b1;
    step();
    step();
    check("t4_done_count", done_cnt, 1);

    // Zero-size frames (N=0, then C=0): Done two cycles after Start
    for (int k = 0; k < 2; k++) begin
      done_cnt = 0;
      Row_Num_Out_REG     = 12'(zn[k]);
      Channel_Out_Num_REG = 10'(zc[k]);
      Start = 1'b1;
      step();
      Start = 1'b0;
      @(negedge clk);
      check("zero_done_early", Done, 0);
      @(negedge clk);
      check("zero_done_pulse", Done, 1);
      check("zero_no_valid", M_Valid, 0);
      step();
      step();
      check("zero_done_count", done_cnt, 1);
    end

    // Reset with 5 beats buffered, then a clean frame
    M_Ready = 1'b0;
    start_frame(2, 3);
    for (int i = 0; i < 5; i++) send(DW'(1024 + i), 1'b0, 1'b0);
    rst = 1'b0;
    step();
    check_reset("midreset");
    rst = 1'b1;
    M_Ready = 1'b1;
    step();
    done_cnt = 0;
    start_frame(2, 3);
    for (int i = 0; i < 12; i++) send(DW'(1280 + i), i == 11, 1'b1);
    wait_q(0, 1'b0);
    step();
    step();
    check("t6_done_count", done_cnt, 1);
    check("t6_no_overflow", Overflow, 0);

    check("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
